// File: rtl/rot_pkg.sv
// Shared types and constants for the rotate-share controller slice.
package rot_pkg;

    localparam int ROT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        ROT_LEFT  = 1'b0,
        ROT_RIGHT = 1'b1
    } dir_t;

endpackage

// File: rtl/rot8_core.sv
// Combinational rotator: log2(W) stages (1/2/4 for W=8), each rotating left or right.
module rot8_core
    import rot_pkg::*;
#(
    parameter  int W  = ROT_W,
    localparam int AW = $clog2(W)
) (
    input  logic [W-1:0]  a,
    input  logic [AW-1:0] amt,
    input  logic          lr,
    output logic [W-1:0]  y
);

    logic [W-1:0] stage;

    // Apply stage i when amt[i] is set; stage i rotates by 2**i positions.
    always_comb begin
        stage = a;
        for (int i = 0; i < AW; i++) begin
            if (amt[i]) begin
                if (lr) begin
                    stage = (stage >> (1 << i)) | (stage << (W - (1 << i)));
                end else begin
                    stage = (stage << (1 << i)) | (stage >> (W - (1 << i)));
                end
            end
        end
        y = stage;
    end

endmodule

// File: rtl/rot_share_ctrl.sv
// Two-requester round-robin controller sharing one rot8_core.
// Optional build macro ROT_SHARE_STATS_EN adds per-requester grant counters.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both high for the same bit. A requester keeps its payload stable while its
// valid is high; ready may depend combinationally on valid. The controller
// holds m_valid and m_y stable until the matching m_ready completes the beat.
module rot_share_ctrl
    import rot_pkg::*;
#(
    parameter  int W        = ROT_W,
    parameter  int CORE_REG = 1,
    localparam int AW       = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    s_valid,
    output logic [1:0]    s_ready,
    input  logic [W-1:0]  s_a0,
    input  logic [W-1:0]  s_a1,
    input  logic [AW-1:0] s_amt0,
    input  logic [AW-1:0] s_amt1,
    input  logic          s_lr0,
    input  logic          s_lr1,
    output logic [1:0]    m_valid,
    input  logic [1:0]    m_ready,
    output logic [W-1:0]  m_y,
    output logic          busy,
    output state_t        state_dbg
`ifdef ROT_SHARE_STATS_EN
    ,
    output logic [15:0]   grant_cnt0,
    output logic [15:0]   grant_cnt1
`endif
);

    state_t        state_q, state_d;
    logic          rr_ptr;
    logic          gid;
    logic [W-1:0]  a_q;
    logic [AW-1:0] amt_q;
    dir_t          lr_q;

    logic          grant_vld;
    logic          grant_id;
    logic [W-1:0]  sel_a;
    logic [AW-1:0] sel_amt;
    logic          sel_lr;
    logic          accept;
    logic          resp_done;

    logic [W-1:0]  core_a;
    logic [AW-1:0] core_amt;
    logic          core_lr;
    logic [W-1:0]  core_y;

    // Round-robin pick: the favoured requester first, otherwise the other one.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = rr_ptr;
        if (s_valid[rr_ptr]) begin
            grant_vld = 1'b1;
            grant_id  = rr_ptr;
        end else if (s_valid[~rr_ptr]) begin
            grant_vld = 1'b1;
            grant_id  = ~rr_ptr;
        end
        sel_a   = grant_id ? s_a1   : s_a0;
        sel_amt = grant_id ? s_amt1 : s_amt0;
        sel_lr  = grant_id ? s_lr1  : s_lr0;
    end

    // In IDLE the core sees the live winner so CORE_REG=0 can capture its result at accept.
    always_comb begin
        if (state_q == IDLE) begin
            core_a   = sel_a;
            core_amt = sel_amt;
            core_lr  = sel_lr;
        end else begin
            core_a   = a_q;
            core_amt = amt_q;
            core_lr  = (lr_q == ROT_RIGHT);
        end
    end

    rot8_core #(.W(W)) u_core (
        .a   (core_a),
        .amt (core_amt),
        .lr  (core_lr),
        .y   (core_y)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and handshake outputs; ready is gated while reset is held.
    always_comb begin
        state_d   = state_q;
        s_ready   = 2'b00;
        m_valid   = 2'b00;
        accept    = 1'b0;
        resp_done = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (grant_vld && rst_n) begin
                    s_ready[grant_id] = 1'b1;
                    accept            = 1'b1;
                    state_d           = (CORE_REG != 0) ? EXEC : RESP;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                m_valid[gid] = 1'b1;
                if (m_ready[gid]) begin
                    resp_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, result register and round-robin pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            amt_q  <= '0;
            lr_q   <= ROT_LEFT;
            gid    <= 1'b0;
            rr_ptr <= 1'b0;
            m_y    <= '0;
        end else begin
            if (accept) begin
                a_q   <= sel_a;
                amt_q <= sel_amt;
                lr_q  <= dir_t'(sel_lr);
                gid   <= grant_id;
                if (CORE_REG == 0) begin
                    m_y <= core_y;
                end
            end
            if (state_q == EXEC) begin
                m_y <= core_y;
            end
            if (resp_done) begin
                rr_ptr <= ~gid;
            end
        end
    end

    assign state_dbg = state_q;

`ifdef ROT_SHARE_STATS_EN
    // Accepted-request counters; wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (accept) begin
            if (grant_id) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end else begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rot_share_ctrl.sv
// Bench for rot_share_ctrl (CORE_REG=1): directed steps plus randomized traffic
// checked against a rotate/arbitration reference model.
module tb_rot_share_ctrl;
    import rot_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  s_valid;
    logic [1:0]  s_ready;
    logic [7:0]  s_a0, s_a1;
    logic [2:0]  s_amt0, s_amt1;
    logic        s_lr0, s_lr1;
    logic [1:0]  m_valid;
    logic [1:0]  m_ready;
    logic [7:0]  m_y;
    logic        busy;
    state_t      state_dbg;
`ifdef ROT_SHARE_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int          id_q[$];
    int          exp_rr;
    int          cnt0, cnt1;

    // Clock
    always #5 clk = ~clk;

    rot_share_ctrl #(.W(8), .CORE_REG(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_a0      (s_a0),
        .s_a1      (s_a1),
        .s_amt0    (s_amt0),
        .s_amt1    (s_amt1),
        .s_lr0     (s_lr0),
        .s_lr1     (s_lr1),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_y       (m_y),
        .busy      (busy),
        .state_dbg (state_dbg)
`ifdef ROT_SHARE_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rotation from its definition: a right rotate by k is a left rotate by W-k.
    function automatic logic [7:0] ref_rot(input logic [7:0] a, input logic [2:0] amt, input logic lr);
        int          k;
        logic [15:0] dbl;
        k   = lr ? (8 - int'(amt)) % 8 : int'(amt);
        dbl = {a, a} << k;
        return dbl[15:8];
    endfunction

    task automatic set_op(input int id, input logic [7:0] a, input logic [2:0] amt, input logic lr);
        if (id == 0) begin
            s_a0 = a; s_amt0 = amt; s_lr0 = lr;
        end else begin
            s_a1 = a; s_amt1 = amt; s_lr1 = lr;
        end
    endtask

    task automatic rand_op(input int id);
        set_op(id, 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    endtask

    task automatic count_grant(input int id);
        if (id == 0) cnt0++; else cnt1++;
    endtask

    // One request from a single requester, with 'hold' cycles of backpressure in RESP.
    task automatic single(input int id, input logic [7:0] a, input logic [2:0] amt,
                          input logic lr, input int hold);
        logic [7:0] y_exp;
        logic [1:0] onehot;
        int         n;
        bit         got;
        y_exp  = ref_rot(a, amt, lr);
        onehot = 2'b01 << id;
        @(posedge clk); #1;
        set_op(id, a, amt, lr);
        s_valid[id] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (s_ready[id] !== 1'b1 && n < 20);
        got = (s_ready[id] === 1'b1);
        check("grant_seen", 32'(got), 32'd1);
        if (!got) begin
            s_valid = 2'b00;
            return;
        end
        check("s_ready_onehot", 32'(s_ready), 32'(onehot));
        @(posedge clk); #1;
        s_valid[id] = 1'b0;
        count_grant(id);
        exp_rr = 1 - id;
        @(negedge clk);
        check("exec_mvalid", 32'(m_valid), 32'd0);
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_sready", 32'(s_ready), 32'd0);
        @(negedge clk);
        check("resp_mvalid", 32'(m_valid), 32'(onehot));
        check("resp_y", 32'(m_y), 32'(y_exp));
        m_ready[1 - id] = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_y", 32'(m_y), 32'(y_exp));
            check("hold_mvalid", 32'(m_valid), 32'(onehot));
            check("hold_busy", 32'(busy), 32'd1);
            check("hold_sready", 32'(s_ready), 32'd0);
        end
        m_ready[id] = 1'b1;
        @(negedge clk);
        check("idle_state", 32'(state_dbg), 32'(IDLE));
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_mvalid", 32'(m_valid), 32'd0);
        m_ready = 2'b00;
    endtask

    // Both requesters valid continuously; grants must alternate from exp_rr.
    task automatic contention(input int ngrant, input bit release_reset);
        int         grants;
        int         cyc;
        int         acc;
        int         rid;
        logic [7:0] y;
        @(posedge clk); #1;
        if (release_reset) rst_n = 1'b1;
        rand_op(0);
        rand_op(1);
        s_valid = 2'b11;
        m_ready = 2'b11;
        grants  = 0;
        cyc     = 0;
        while (grants < ngrant && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (m_valid !== 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("spurious_mvalid", 32'(m_valid), 32'd0);
                end else begin
                    y   = exp_q.pop_front();
                    rid = id_q.pop_front();
                    check("cont_mvalid", 32'(m_valid), 32'(2'b01 << rid));
                    check("cont_y", 32'(m_y), 32'(y));
                end
            end
            acc = -1;
            if (s_ready !== 2'b00) begin
                check("cont_grant", 32'(s_ready), 32'(2'b01 << exp_rr));
                acc = (s_ready[1] === 1'b1) ? 1 : 0;
                if (acc == 0) exp_q.push_back(ref_rot(s_a0, s_amt0, s_lr0));
                else          exp_q.push_back(ref_rot(s_a1, s_amt1, s_lr1));
                id_q.push_back(acc);
            end
            @(posedge clk); #1;
            if (acc >= 0) begin
                grants++;
                count_grant(acc);
                exp_rr = 1 - acc;
                rand_op(acc);
            end
        end
        check("cont_done", 32'(grants), 32'(ngrant));
        s_valid = 2'b00;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (m_valid !== 2'b00) begin
                y   = exp_q.pop_front();
                rid = id_q.pop_front();
                check("drain_mvalid", 32'(m_valid), 32'(2'b01 << rid));
                check("drain_y", 32'(m_y), 32'(y));
            end
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        m_ready = 2'b00;
    endtask

    initial begin
        int  n;
        bit  quiet;
        // Reset block: both requesters already asking while reset is held.
        rst_n   = 1'b0;
        s_valid = 2'b11;
        m_ready = 2'b00;
        set_op(0, 8'h00, 3'd0, 1'b0);
        set_op(1, 8'h00, 3'd0, 1'b0);
        exp_rr = 0;
        cnt0   = 0;
        cnt1   = 0;
        repeat (2) @(negedge clk);
        check("rst_sready", 32'(s_ready), 32'd0);
        check("rst_mvalid", 32'(m_valid), 32'd0);
        check("rst_my", 32'(m_y), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));

        // Contention from reset: 4 grants each, starting with requester 0.
        contention(8, 1'b1);

        // Directed rotations.
        single(0, 8'hB4, 3'd3, 1'b1, 0);
        single(1, 8'h81, 3'd1, 1'b0, 0);
        single(1, 8'h5A, 3'd0, 1'b1, 0);
        // Backpressure for 5 cycles.
        single(0, 8'hC3, 3'd7, 1'b0, 5);

        // Random single requests.
        for (int i = 0; i < 10; i++) begin
            single(int'($urandom_range(0, 1)), 8'($urandom), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Contention from a non-reset pointer.
        contention(6, 1'b0);

        // Reset during EXEC.
        @(posedge clk); #1;
        set_op(0, 8'hF0, 3'd2, 1'b1);
        s_valid = 2'b01;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (s_ready[0] !== 1'b1 && n < 20);
        check("midrst_grant", 32'(s_ready[0] === 1'b1), 32'd1);
        @(posedge clk); #1;
        s_valid = 2'b00;
        @(negedge clk);
        check("midrst_in_exec", 32'(state_dbg), 32'(EXEC));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_my", 32'(m_y), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mvalid", 32'(m_valid), 32'd0);
        check("midrst_sready", 32'(s_ready), 32'd0);
        check("midrst_state", 32'(state_dbg), 32'(IDLE));
        exp_rr = 0;
        cnt0   = 0;
        cnt1   = 0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 2'b11;
        quiet   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (m_valid !== 2'b00 || busy !== 1'b0) quiet = 1'b0;
        end
        check("postrst_quiet", 32'(quiet), 32'd1);
        m_ready = 2'b00;

        // Grant tally after reset: 3 for requester 0, 2 for requester 1.
        single(0, 8'h01, 3'd1, 1'b0, 0);
        single(0, 8'h02, 3'd2, 1'b1, 0);
        single(1, 8'h03, 3'd3, 1'b0, 1);
        single(0, 8'h04, 3'd4, 1'b1, 0);
        single(1, 8'h05, 3'd5, 1'b1, 0);
`ifdef ROT_SHARE_STATS_EN
        check("grant_cnt0", 32'(grant_cnt0), 32'(cnt0));
        check("grant_cnt1", 32'(grant_cnt1), 32'(cnt1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rot_share_ctrl.md
Name: rot_share_ctrl

Overview:
- Two-requester controller that time-shares one 8-bit rotate datapath (left/right rotate by 0..7) between independent clients.
- Round-robin arbitration, valid/ready handshakes on request and response sides, operand capture and result registering.
- Sits between client FSMs (e.g. a display scroller and a CRC helper) and the combinational rotator core.

Parameters:
- W, 8, data width in bits; power of two, 8 is the only verified value.
- AW, $clog2(W), rotate-amount width; localparam, never overridden.
- CORE_REG, 1, 1 = extra EXEC cycle registering the core output; 0 = result captured in the accept cycle.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  2  per-requester request valid
- s_ready  out  2  per-requester accept; one-hot or zero
- s_a0, s_a1  in  W each  operand from requester 0 / 1
- s_amt0, s_amt1  in  AW each  rotate amount from requester 0 / 1
- s_lr0, s_lr1  in  1 each  1 = rotate right, 0 = rotate left
- m_valid  out  2  per-requester result valid; one-hot or zero
- m_ready  in  2  per-requester result accept
- m_y  out  W  result, shared bus, meaningful only while the matching m_valid bit is set
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0 (requester 0 favoured), s_ready=0, m_valid=0, m_y=0, busy=0; captured operands cleared to 0.
- Reset mid-operation aborts it: no m_valid is produced for the in-flight request.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = the rr_ptr requester if its s_valid is set, else the other requester if its s_valid is set, else none.
  - s_ready[grant] is asserted combinationally from s_valid and rr_ptr; no other s_ready bit is ever set.
  - Transfer occurs on s_valid & s_ready: capture a/amt/lr and the grant id.
  - Next state is EXEC if CORE_REG=1; if CORE_REG=0, m_y is loaded with the core output now and the next state is RESP.
- EXEC: m_y <= rot(captured a, amt, lr); next state RESP. Takes exactly 1 cycle; no s_ready.
- RESP:
  - m_valid[gid]=1 and m_y is held stable until m_ready[gid]=1; m_ready of the non-granted requester is ignored.
  - On handshake: m_valid cleared, rr_ptr <= ~gid, next state IDLE.
- Latency (CORE_REG=1): accept at cycle t, m_valid high in cycle t+2. Minimum issue interval is 3 cycles; 2 cycles with CORE_REG=0.
- No request is accepted while in EXEC or RESP, so there is never more than one outstanding request.
- Rotate arithmetic: amt is taken mod W, no overflow possible; amt=0 passes a unchanged; lr is ignored when amt=0.
- Right rotate by k equals left rotate by W-k.
- A requester may drop s_valid before it is granted; the request is then simply lost, with no error.
- Both s_valid bits high in IDLE: the rr_ptr requester wins and the other is served next, so neither starves.

Optional Feature:
- Macro ROT_SHARE_STATS_EN.
- Defined: adds outputs grant_cnt0 and grant_cnt1 (16 bits each). Each counts accepted requests for its requester, wraps 16'hFFFF->0, and resets to 0.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package rot_pkg holds:
  - state_t enum {IDLE, EXEC, RESP}
  - localparam ROT_W=8
  - dir_t enum {ROT_LEFT=0, ROT_RIGHT=1}
- One sub-module: rot8_core, a purely combinational 3-stage (1/2/4) left/right rotator with ports a, amt, lr, y. It is instantiated once inside rot_share_ctrl.

Test Plan:
- Right rotate: req0 a=8'hB4 amt=3 lr=1, m_ready tied 1 -> m_valid[0] two cycles after accept, m_y=8'h96.
- Left rotate and amt=0: req1 a=8'h81 amt=1 lr=0 -> m_y=8'h03. Then a=8'h5A amt=0 lr=1 -> m_y=8'h5A.
- Contention: both s_valid held high continuously from reset, 4 requests each -> grants alternate 0,1,0,1..., starting with 0, and s_ready is never two-hot.
- Backpressure: m_ready[0]=0 for 5 cycles in RESP -> m_y and m_valid stable, busy=1, s_ready=0 for all 5 cycles. Raise m_ready -> IDLE next cycle.
- Reset mid-op: deassert rst_n during EXEC -> outputs go to 0 immediately with no clock; after release, no m_valid until a new request.
- ROT_SHARE_STATS_EN defined: 3 grants to req0 and 2 to req1 -> grant_cnt0=3, grant_cnt1=2.
